readout_rx_state_decision_accumulator: RTL and testbench
========================================================

# readout_rx_state_decision_accumulator

Integrates demodulated I/Q samples over a programmable window and applies a linear discriminant, score = W_I·ΣI + W_Q·ΣQ, against a threshold. It sits directly upstream of the readout RX state-decision output logic. It drives that stage's `finish_count_in` with a one-cycle pulse, and its `meas_result_condition` with the discriminant outcome. One instance serves one qubit readout channel.

## Interface
- `SAMPLE_WIDTH`, default 8: signed I/Q sample width.
- `COUNT_WIDTH`, default 10: integration-length and sample-counter width.
- `WEIGHT_WIDTH`, default 8: signed discriminant weight width.
- `ACC_WIDTH`, default 20: signed accumulator and threshold width. Must be ≥ SAMPLE_WIDTH+COUNT_WIDTH.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserting it low clears all state immediately.
- `start_in` in 1: single-cycle request to open an integration window.
- `abort_in` in 1: synchronous abort of the window in progress.
- `integ_len_in` in COUNT_WIDTH: number of samples to integrate. Unsigned; sampled only on an accepted start.
- `valid_sample_in` in 1: I/Q sample valid.
- `i_sample_in` in SAMPLE_WIDTH: signed I sample.
- `q_sample_in` in SAMPLE_WIDTH: signed Q sample.
- `weight_i_in` in WEIGHT_WIDTH: signed I weight. Quasi-static; sampled in DECIDE.
- `weight_q_in` in WEIGHT_WIDTH: signed Q weight. Quasi-static; sampled in DECIDE.
- `threshold_in` in ACC_WIDTH: signed threshold, sign-extended for comparison.
- `busy_out` out 1: high while in INTEG or DECIDE.
- `finish_count_out` out 1: one-cycle pulse when a decision is available.
- `meas_result_condition_out` out 1: 1 iff score > threshold.

## Operation
- FSM states: IDLE, INTEG, DECIDE. Reset state is IDLE.
- **IDLE**
  - `start_in`=1 with `integ_len_in`≠0: latch the length, clear acc_i, acc_q and count, go to INTEG.
  - `start_in` with `integ_len_in`=0: ignored; remain in IDLE.
  - `valid_sample_in` in IDLE: ignored, including in the same cycle as an accepted start.
- **INTEG**
  - Each cycle with `valid_sample_in`=1: acc_i += sign-extended I, acc_q += sign-extended Q, count += 1.
  - Gaps in `valid_sample_in` are allowed; the window has no timeout.
  - When a sample is accepted with count = len−1, go to DECIDE.
  - `start_in` in INTEG: ignored. No restart.
- **DECIDE** (exactly one cycle)
  - Compute score = weight_i·acc_i + weight_q·acc_q at full width, ACC_WIDTH+WEIGHT_WIDTH+1 signed. No truncation.
  - Compare score > threshold, signed and strict (equal gives 0).
  - At the closing edge: register finish_count_out=1 and meas_result_condition_out=result, then go to IDLE.
  - `valid_sample_in` in DECIDE: ignored.
- **Abort**
  - `abort_in`=1 in INTEG or DECIDE: go to IDLE at the next edge. No finish pulse; meas_result_condition_out keeps its previous value.
  - Abort has priority over sample acceptance and over the DECIDE completion in the same cycle.
  - `abort_in` in IDLE has no effect, and it also blocks a `start_in` presented in the same cycle.
- **Arithmetic**
  - Accumulators cannot overflow, by the ACC_WIDTH rule.
  - The product sum is computed wide, so no saturation is needed.
- **Output holding**
  - meas_result_condition_out is held from one finish pulse until the next finish pulse or reset.
  - finish_count_out is 0 in every cycle other than the pulse.

## Timing
- Reset values: busy_out=0, finish_count_out=0, meas_result_condition_out=0, state=IDLE, accumulators and count = 0.
- Start accepted at edge e0: busy_out=1 from e0.
- Last sample accepted at edge k: state=DECIDE after k.
- At edge k+1: finish_count_out=1 and meas_result_condition_out valid, state=IDLE, busy_out=0.
- At edge k+2: finish_count_out=0.
- Minimum start-to-finish: len+1 edges after the accepting edge, with continuous valid.
- A new start is accepted from the cycle in which finish_count_out is high, so back-to-back windows are possible.
- Reset asserted mid-operation: all outputs go to 0 asynchronously; the in-flight window is lost with no pulse.

## Test plan
1. **Strict threshold.** len=4, I=10 on 4 consecutive cycles, Q=0, w_i=1, w_q=0.
   - threshold=39 → one finish pulse 2 edges after the 4th sample, condition=1.
   - Repeat with threshold=40 → condition=0.
2. **Valid gaps.** len=3 with valid pattern 1,0,0,1,0,1; I=−128, w_i=−1, threshold=383.
   - finish pulse exactly 2 edges after the 3rd valid sample.
   - score=384 → condition=1.
3. **Q path and negative weights.** len=2, I=5, Q=−7, w_i=2, w_q=3, threshold=−23.
   - score=−22 → condition=1.
   - threshold=−22 → condition=0.
4. **Abort.** Abort after 2 of 5 samples → no finish pulse, busy_out=0 next cycle, condition unchanged.
   - A subsequent start with len=1 completes normally.
5. **Async reset.** rst low mid-INTEG → all outputs 0 immediately.
   - After release, a start with len=1, I=1, w_i=1, threshold=0 → condition=1.
6. **Ignored starts.** start with len=0 → busy_out stays 0. start pulsed during INTEG → window length unchanged, only one finish pulse.

Source files
------------

// File: rtl/readout_rx_state_decision_accumulator.sv
// readout_rx_state_decision_accumulator: windowed I/Q integrator with a linear discriminant decision
//   clk                        : rising-edge clock
//   rst                        : asynchronous active-low reset
//   start_in, integ_len_in     : open a window of integ_len_in samples (zero length ignored)
//   abort_in                   : drop the window in progress, no decision
//   valid_sample_in, i/q_sample_in : signed demodulated samples
//   weight_i_in, weight_q_in   : signed discriminant weights, used in DECIDE
//   threshold_in               : signed threshold, score must strictly exceed it
//   busy_out                   : window open (INTEG or DECIDE)
//   finish_count_out           : one-cycle pulse with each decision
//   meas_result_condition_out  : latest decision, held between pulses
module readout_rx_state_decision_accumulator #(
   parameter int SAMPLE_WIDTH = 8,
   parameter int COUNT_WIDTH  = 10,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACC_WIDTH    = 20
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start_in,
   input  logic                           abort_in,
   input  logic        [COUNT_WIDTH-1:0]  integ_len_in,
   input  logic                           valid_sample_in,
   input  logic signed [SAMPLE_WIDTH-1:0] i_sample_in,
   input  logic signed [SAMPLE_WIDTH-1:0] q_sample_in,
   input  logic signed [WEIGHT_WIDTH-1:0] weight_i_in,
   input  logic signed [WEIGHT_WIDTH-1:0] weight_q_in,
   input  logic signed [ACC_WIDTH-1:0]    threshold_in,
   output logic                           busy_out,
   output logic                           finish_count_out,
   output logic                           meas_result_condition_out
);
   localparam int SCORE_WIDTH = ACC_WIDTH + WEIGHT_WIDTH + 1;
   localparam logic [1:0] IDLE = 2'd0, INTEG = 2'd1, DECIDE = 2'd2;
   logic [1:0] state;
   logic [COUNT_WIDTH-1:0] len, count;
   logic signed [ACC_WIDTH-1:0] acc_i, acc_q, ext_i, ext_q;
   logic signed [SCORE_WIDTH-1:0] score, thr_ext;
   logic accept, last;
   // Score is wide enough for both full-scale products plus their sum, so the
   // modular product of the sign-extended operands is exact.
   always_comb begin
      ext_i    = {{(ACC_WIDTH-SAMPLE_WIDTH){i_sample_in[SAMPLE_WIDTH-1]}}, i_sample_in};
      ext_q    = {{(ACC_WIDTH-SAMPLE_WIDTH){q_sample_in[SAMPLE_WIDTH-1]}}, q_sample_in};
      score    = {{(ACC_WIDTH+1){weight_i_in[WEIGHT_WIDTH-1]}}, weight_i_in}
               * {{(WEIGHT_WIDTH+1){acc_i[ACC_WIDTH-1]}}, acc_i}
               + {{(ACC_WIDTH+1){weight_q_in[WEIGHT_WIDTH-1]}}, weight_q_in}
               * {{(WEIGHT_WIDTH+1){acc_q[ACC_WIDTH-1]}}, acc_q};
      thr_ext  = {{(WEIGHT_WIDTH+1){threshold_in[ACC_WIDTH-1]}}, threshold_in};
      accept   = start_in && !abort_in && (integ_len_in != '0);
      last     = count == len - COUNT_WIDTH'(1);
      busy_out = state != IDLE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                     <= IDLE;
         len                       <= '0;
         count                     <= '0;
         acc_i                     <= '0;
         acc_q                     <= '0;
         finish_count_out          <= 1'b0;
         meas_result_condition_out <= 1'b0;
      end else begin
         finish_count_out <= 1'b0;
         if (state == IDLE) begin
            if (accept) begin
               state <= INTEG;
               len   <= integ_len_in;
               count <= '0;
               acc_i <= '0;
               acc_q <= '0;
            end
         end else if (abort_in) begin
            state <= IDLE;
         end else if (state == INTEG) begin
            if (valid_sample_in) begin
               acc_i <= acc_i + ext_i;
               acc_q <= acc_q + ext_q;
               count <= count + COUNT_WIDTH'(1);
               state <= last ? DECIDE : INTEG;
            end
         end else if (state == DECIDE) begin
            finish_count_out          <= 1'b1;
            meas_result_condition_out <= score > thr_ext;
            state                     <= IDLE;
         end else begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_readout_rx_state_decision_accumulator.sv
// tb_readout_rx_state_decision_accumulator: randomized and directed windows against a sum-of-samples model
module tb_readout_rx_state_decision_accumulator;
   localparam int SW = 8, CW = 10, WW = 8, AW = 20;
   logic clk = 1'b0, rst = 1'b0, start_in = 1'b0, abort_in = 1'b0, valid_sample_in = 1'b0;
   logic [CW-1:0] integ_len_in = '0;
   logic signed [SW-1:0] i_sample_in = '0, q_sample_in = '0;
   logic signed [WW-1:0] weight_i_in = '0, weight_q_in = '0;
   logic signed [AW-1:0] threshold_in = '0;
   logic busy_out, finish_count_out, meas_result_condition_out;
   int errs = 0, checks = 0;
   bit last_cond = 1'b0;
   always #5 clk = ~clk;
   readout_rx_state_decision_accumulator #(
      .SAMPLE_WIDTH(SW), .COUNT_WIDTH(CW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW)
   ) dut (
      .clk(clk), .rst(rst), .start_in(start_in), .abort_in(abort_in),
      .integ_len_in(integ_len_in), .valid_sample_in(valid_sample_in),
      .i_sample_in(i_sample_in), .q_sample_in(q_sample_in),
      .weight_i_in(weight_i_in), .weight_q_in(weight_q_in), .threshold_in(threshold_in),
      .busy_out(busy_out), .finish_count_out(finish_count_out),
      .meas_result_condition_out(meas_result_condition_out)
   );
   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   function automatic int rs();
      return int'($urandom_range(0, 255)) - 128;
   endfunction
   task automatic idle_chk;
      step;
      chk("idle_fin", finish_count_out, 0);
      chk("idle_busy", busy_out, 0);
      chk("idle_cond", meas_result_condition_out, last_cond);
   endtask
   task automatic randomize_samples;
      i_sample_in = SW'(rs());
      q_sample_in = SW'(rs());
   endtask
   // One complete window; gaps packs 2-bit idle-cycle counts per sample when not random.
   task automatic window(input int len, input int iv, input int qv, input bit rnd, input int gaps,
                         input int wi, input int wq, input longint thr);
      longint si = 0, sq = 0, score, t = thr;
      int x, y, g;
      weight_i_in = WW'(wi);
      weight_q_in = WW'(wq);
      threshold_in = AW'(thr);
      integ_len_in = CW'(len);
      start_in = 1'b1;
      abort_in = 1'b0;
      valid_sample_in = 1'($urandom);
      randomize_samples();
      step;
      start_in = 1'b0;
      integ_len_in = CW'($urandom);
      chk("start_busy", busy_out, 1);
      chk("start_fin", finish_count_out, 0);
      for (int k = 0; k < len; k++) begin
         g = rnd ? int'($urandom_range(0, 2)) : (gaps >> (2 * k)) & 3;
         for (int j = 0; j < g; j++) begin
            valid_sample_in = 1'b0;
            start_in = rnd ? 1'($urandom) : 1'b1;
            randomize_samples();
            step;
            chk("gap_busy", busy_out, 1);
            chk("gap_fin", finish_count_out, 0);
         end
         x = rnd ? rs() : iv;
         y = rnd ? rs() : qv;
         valid_sample_in = 1'b1;
         start_in = 1'b0;
         i_sample_in = SW'(x);
         q_sample_in = SW'(y);
         si += x;
         sq += y;
         step;
         chk("integ_busy", busy_out, 1);
         chk("integ_fin", finish_count_out, 0);
      end
      score = longint'(wi) * si + longint'(wq) * sq;
      if (rnd) begin
         t = score + int'($urandom_range(0, 2)) - 1;
         if (t > 524287 || t < -524288) t = longint'(rs()) * 1000;
         threshold_in = AW'(t);
      end
      valid_sample_in = 1'($urandom);
      randomize_samples();
      step;
      last_cond = score > t;
      chk("fin_pulse", finish_count_out, 1);
      chk("done_busy", busy_out, 0);
      chk("cond", meas_result_condition_out, last_cond);
      valid_sample_in = 1'b0;
   endtask
   initial begin
      #3;
      chk("rst_busy", busy_out, 0);
      chk("rst_fin", finish_count_out, 0);
      chk("rst_cond", meas_result_condition_out, 0);
      @(negedge clk);
      rst = 1'b1;
      idle_chk();
      window(4, 10, 0, 0, 0, 1, 0, 39);
      idle_chk();
      window(4, 10, 0, 0, 0, 1, 0, 40);
      idle_chk();
      window(3, -128, 0, 0, 24, -1, 0, 383);
      window(2, 5, -7, 0, 0, 2, 3, -23);
      window(2, 5, -7, 0, 0, 2, 3, -22);
      idle_chk();
      integ_len_in = '0;
      start_in = 1'b1;
      step;
      start_in = 1'b0;
      chk("len0_busy", busy_out, 0);
      integ_len_in = CW'(3);
      start_in = 1'b1;
      abort_in = 1'b1;
      step;
      start_in = 1'b0;
      abort_in = 1'b0;
      chk("abort_idle_busy", busy_out, 0);
      window(3, 1, 1, 0, 21, 1, 1, 5);
      idle_chk();
      integ_len_in = CW'(5);
      start_in = 1'b1;
      step;
      start_in = 1'b0;
      valid_sample_in = 1'b1;
      repeat (2) step;
      abort_in = 1'b1;
      step;
      abort_in = 1'b0;
      valid_sample_in = 1'b0;
      chk("abort_busy", busy_out, 0);
      chk("abort_fin", finish_count_out, 0);
      chk("abort_cond", meas_result_condition_out, last_cond);
      repeat (3) idle_chk();
      integ_len_in = CW'(1);
      start_in = 1'b1;
      step;
      start_in = 1'b0;
      valid_sample_in = 1'b1;
      step;
      valid_sample_in = 1'b0;
      abort_in = 1'b1;
      step;
      abort_in = 1'b0;
      chk("abort_dec_busy", busy_out, 0);
      chk("abort_dec_fin", finish_count_out, 0);
      idle_chk();
      window(1, 1, 0, 0, 0, 1, 0, 0);
      integ_len_in = CW'(5);
      start_in = 1'b1;
      step;
      start_in = 1'b0;
      valid_sample_in = 1'b1;
      repeat (2) step;
      valid_sample_in = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_busy", busy_out, 0);
      chk("arst_fin", finish_count_out, 0);
      chk("arst_cond", meas_result_condition_out, 0);
      last_cond = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) idle_chk();
      window(1, 1, 0, 0, 0, 1, 0, 0);
      repeat (40) begin
         window(int'($urandom_range(1, 8)), 0, 0, 1, 0, rs(), rs(), 0);
         if ($urandom_range(0, 1) == 1) idle_chk();
      end
      window(1023, 0, 0, 1, 0, rs(), rs(), 0);
      idle_chk();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
